shift_seq_ctrl: RTL
===================

// Module: shift_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the operand-2 shifter path of the pipeline.
//  - Accepts one shifter operation over a valid/ready handshake.
//  - Steps a 1-bit-per-cycle shift/rotate engine and computes ARM-style carry-out.
//  - Presents result and carry with valid/ready back-pressure.
//  - Replaces the single-cycle loop shifter where timing closure requires iteration.
// PARAMETERS
//  DATA_W  32  operand/result width; only 32 legal
//  CNT_W   6   step-counter width; must hold 0..32
// PORTS
//  clk         in   1       system clock; all state updates on rising edge
//  rst_n       in   1       synchronous, active-low reset
//  in_valid    in   1       request valid
//  in_ready    out  1       request accepted when in_valid & in_ready at clk edge
//  in_a        in   DATA_W  register operand to shift
//  in_instr    in   32      instruction: [27:25] op, [6:5] typ, [11:7] amt5, [11:8] rot4, [7:0] imm8, [11:0] imm12
//  in_c        in   1       current CPSR C flag
//  flush       in   1       abort current operation (pipeline flush)
//  out_valid   out  1       result valid
//  out_ready   in   1       consumer ready; transfer when out_valid & out_ready
//  out_result  out  DATA_W  shifter operand result
//  out_carry   out  1       shifter carry-out
//  out_err     out  1       op class unsupported (op >= 3'b011)
//  busy        out  1       high in SHIFT or DONE
// BEHAVIOUR
//  Reset: clk and rst_n only; rst_n is synchronous, active-low.
//   rst_n=0 at edge -> IDLE, counter 0, out_result 0, out_carry 0, out_err 0, out_valid 0.
//   Overrides any operation in progress.
//  FSM: IDLE -> SHIFT or DONE; SHIFT -> DONE; DONE -> IDLE.
//   in_ready = (state==IDLE); out_valid = (state==DONE); busy = !in_ready.
//  Accept edge: latch working reg W, carry, and step count N:
//   op=000 LSL: amt=0 -> W=A, N=0, C=in_c. Else W=A, N=amt, C=A[32-amt].
//   op=000 LSR: amt=0 means 32 -> C=A[31], result 0. Else N=amt, C=A[amt-1], zero fill.
//   op=000 ASR: amt=0 means 32 -> C=A[31], result={32{A[31]}}. Else N=amt, C=A[amt-1], sign fill.
//   op=000 ROR: amt=0 is RRX -> N=1, fill bit=in_c, C=A[0]. Else N=amt, C=A[amt-1].
//   op=001: W={24'b0,imm8}, N=2*rot4, ROR. C=in_c if rot4=0, else final W[31].
//   op=010: W={20'b0,imm12}, N=0, C=in_c.
//   op>=011: W=A, N=0, C=in_c, out_err=1.
//  Step: SHIFT performs exactly one bit step per edge and decrements the counter.
//   SHIFT->DONE on the edge that consumes the last step.
//   N=0 goes straight from accept to DONE.
//  Latency: out_valid high after N edges following the accept edge, minimum 0
//   (out_valid seen the cycle after accept).
//  DONE: out_result/out_carry/out_err held stable until out_valid & out_ready.
//   Then -> IDLE. No new accept in the same edge.
//   Throughput: at most 1 op per N+2 cycles.
//  flush=1 at edge in SHIFT/DONE -> IDLE, out_valid 0, result discarded.
//   flush in IDLE blocks acceptance that edge. Priority: rst_n > flush > handshake.
//  in_* sampled only at the accept edge; changes while busy are ignored.
// CONFIGURATION
//  SHIFT_SEQ_EARLY_ZERO_EN defined:
//   LSR#0 and ASR#0 (the 32-bit cases) load the final result directly with N=0.
//  SHIFT_SEQ_EARLY_ZERO_EN undefined:
//   those cases run N=32 single-bit steps; worst-case latency 32.
//  Results and carry are identical in both builds; only latency differs.
// TESTING
//  1 LSL: op=000 typ=00 amt=4, A=0x1000000F -> 0x000000F0, C=1; out_valid 4 edges after accept.
//  2 Rot-imm: op=001 imm8=0xFF rot4=4 -> 0xFF000000, C=1, latency 8.
//    Same with rot4=0, in_c=0 -> 0x000000FF, C=0, latency 0.
//  3 Zero-amt LSR: A=0x80000001 typ=01 amt=0 -> result 0, C=1.
//    Latency 32 without the macro, 0 with it. ASR#0 with the same A -> 0xFFFFFFFF, C=1.
//  4 RRX: typ=11 amt=0, A=0x00000003, in_c=1 -> 0x80000001, C=1, latency 1.
//    Imm offset op=010 imm12=0xABC -> 0x00000ABC, C=in_c.
//  5 Back-pressure: hold out_ready=0 for 5 cycles in DONE.
//    Outputs stable, in_ready=0. Transfer on the first out_ready=1 edge, in_ready=1 next cycle.
//  6 Flush/reset: flush at step 3 of an 8-step op -> IDLE next edge, no out_valid.
//    rst_n=0 mid-op -> all outputs 0 next edge. op=101 -> out_err=1, result=A.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// Purpose: iterative operand-2 shifter (LSL/LSR/ASR/ROR/RRX, rotated imm8, imm12) with ARM carry-out.
// Latency: N edges after accept (N = step count, 0..32); N=0 gives out_valid the cycle after accept.
// Backpressure: in_ready only in IDLE; result/carry/err held in DONE until out_valid & out_ready.
// Build option: SHIFT_SEQ_EARLY_ZERO_EN loads LSR#32/ASR#32 results directly instead of stepping 32 times.
module shift_seq_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [31:0]       in_instr,
    input  logic              in_c,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_err,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] M_LSL = 2'b00;
    localparam logic [1:0] M_LSR = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    logic [1:0]        state;
    logic [DATA_W-1:0] w;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        mode;
    logic              rrx;
    logic              fill;
    logic              carry;
    logic              carry_final;
    logic              err;

    // Instruction fields
    logic [2:0] op;
    logic [1:0] typ;
    logic [4:0] amt;
    logic [3:0] rot4;
    assign op   = in_instr[27:25];
    assign typ  = in_instr[6:5];
    assign amt  = in_instr[11:7];
    assign rot4 = in_instr[11:8];

    // Bits of the instruction word the shifter never looks at
    logic unused_instr;
    assign unused_instr = ^{in_instr[31:28], in_instr[24:12]};

    // Load values computed from the request, consumed only on the accept edge
    logic [DATA_W-1:0] ld_w;
    logic [CNT_W-1:0]  ld_n;
    logic [1:0]        ld_mode;
    logic              ld_c;
    logic              ld_rrx;
    logic              ld_cfin;
    logic              ld_err;

    // Decode the request into working value, step count, step mode and initial carry
    always_comb begin
        ld_w    = in_a;
        ld_n    = '0;
        ld_mode = typ;
        ld_c    = in_c;
        ld_rrx  = 1'b0;
        ld_cfin = 1'b0;
        ld_err  = 1'b0;
        case (op)
            3'b000: begin
                case (typ)
                    M_LSL: begin
                        if (amt != 5'd0) begin
                            ld_n = CNT_W'(amt);
                            ld_c = in_a[5'd0 - amt];      // bit 32-amt, modulo 32
                        end
                    end
                    M_LSR: begin
                        if (amt == 5'd0) begin
                            ld_c = in_a[DATA_W-1];
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
                            ld_w = '0;
`else
                            ld_n = CNT_W'(DATA_W);
`endif
                        end else begin
                            ld_n = CNT_W'(amt);
                            ld_c = in_a[amt - 5'd1];
                        end
                    end
                    M_ASR: begin
                        if (amt == 5'd0) begin
                            ld_c = in_a[DATA_W-1];
`ifdef SHIFT_SEQ_EARLY_ZERO_EN
                            ld_w = {DATA_W{in_a[DATA_W-1]}};
`else
                            ld_n = CNT_W'(DATA_W);
`endif
                        end else begin
                            ld_n = CNT_W'(amt);
                            ld_c = in_a[amt - 5'd1];
                        end
                    end
                    default: begin
                        if (amt == 5'd0) begin
                            // RRX: one rotate step with the old C flag entering at the top
                            ld_n   = CNT_W'(1);
                            ld_rrx = 1'b1;
                            ld_c   = in_a[0];
                        end else begin
                            ld_n = CNT_W'(amt);
                            ld_c = in_a[amt - 5'd1];
                        end
                    end
                endcase
            end
            3'b001: begin
                ld_w    = DATA_W'(in_instr[7:0]);
                ld_n    = CNT_W'({rot4, 1'b0});
                ld_mode = M_ROR;
                // Non-zero rotation: carry is the final bit 31, captured on the last step
                ld_cfin = (rot4 != 4'd0);
            end
            3'b010: begin
                ld_w = DATA_W'(in_instr[11:0]);
            end
            default: begin
                ld_err = 1'b1;
            end
        endcase
    end

    // One-bit step of the working register
    logic [DATA_W-1:0] w_step;
    always_comb begin
        w_step = w;
        case (mode)
            M_LSL:   w_step = {w[DATA_W-2:0], 1'b0};
            M_LSR:   w_step = {1'b0, w[DATA_W-1:1]};
            M_ASR:   w_step = {w[DATA_W-1], w[DATA_W-1:1]};
            default: w_step = {(rrx ? fill : w[0]), w[DATA_W-1:1]};
        endcase
    end

    // Sequencer: reset beats flush, flush beats the handshakes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            w           <= '0;
            cnt         <= '0;
            mode        <= M_LSL;
            rrx         <= 1'b0;
            fill        <= 1'b0;
            carry       <= 1'b0;
            carry_final <= 1'b0;
            err         <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        w           <= ld_w;
                        cnt         <= ld_n;
                        mode        <= ld_mode;
                        rrx         <= ld_rrx;
                        fill        <= in_c;
                        carry       <= ld_c;
                        carry_final <= ld_cfin;
                        err         <= ld_err;
                        state       <= (ld_n == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    w   <= w_step;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= ST_DONE;
                        if (carry_final) carry <= w_step[DATA_W-1];
                    end
                end
                ST_DONE: begin
                    if (out_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign busy       = !in_ready;
    assign out_result = w;
    assign out_carry  = carry;
    assign out_err    = err;

endmodule
